// File: rtl/food_rng.sv
// rtl/food_rng.sv - food-position generator: 32-bit LFSR, in-grid and occupancy rejection, req/valid handshake
// Optional occupancy check state is built when FOOD_RNG_OCC_CHECK_EN is defined.
module food_rng #(
    parameter int          X_BITS    = 7,
    parameter int          Y_BITS    = 7,
    parameter int          GRID_W    = 80,
    parameter int          GRID_H    = 60,
    parameter logic [31:0] SEED      = 32'hACE1_2469,
    parameter int          MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [31:0]       seed_in,
    input  logic              req,
    input  logic              ack,
    output logic              valid,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              fail,
    output logic              busy,
    output logic              chk_valid,
    output logic [X_BITS-1:0] chk_x,
    output logic [Y_BITS-1:0] chk_y,
    input  logic              occ
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
`ifdef FOOD_RNG_OCC_CHECK_EN
        S_CHECK  = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_lfsr;
    logic [TW-1:0]     r_tries;
    logic [TW-1:0]     w_tries_nxt;
    logic [X_BITS-1:0] r_food_x;
    logic [X_BITS-1:0] w_food_x_nxt;
    logic [Y_BITS-1:0] r_food_y;
    logic [Y_BITS-1:0] w_food_y_nxt;
    logic              r_fail;
    logic              w_fail_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_busy;

    logic              w_lfsr_fb;
    logic [X_BITS-1:0] w_cx;
    logic [Y_BITS-1:0] w_cy;
    logic              w_in_range;
    logic              w_last_try;

    // x^32 + x^22 + x^2 + x + 1, shifted left with feedback into bit 0
    assign w_lfsr_fb  = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
    assign w_cx       = r_lfsr[X_BITS-1:0];
    assign w_cy       = r_lfsr[X_BITS+Y_BITS-1:X_BITS];
    assign w_in_range = (32'(w_cx) < 32'(GRID_W)) && (32'(w_cy) < 32'(GRID_H));
    assign w_last_try = (r_tries == TW'(MAX_TRIES - 1));

`ifdef FOOD_RNG_OCC_CHECK_EN
    logic [X_BITS-1:0] r_cand_x;
    logic [X_BITS-1:0] w_cand_x_nxt;
    logic [Y_BITS-1:0] r_cand_y;
    logic [Y_BITS-1:0] w_cand_y_nxt;

    assign chk_valid = (r_state == S_CHECK);
    assign chk_x     = chk_valid ? r_cand_x : '0;
    assign chk_y     = chk_valid ? r_cand_y : '0;
`else
    logic w_unused_occ;

    assign w_unused_occ = occ;
    assign chk_valid    = 1'b0;
    assign chk_x        = '0;
    assign chk_y        = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_tries_nxt  = r_tries;
        w_food_x_nxt = r_food_x;
        w_food_y_nxt = r_food_y;
        w_fail_nxt   = r_fail;
        w_valid_nxt  = r_valid;
`ifdef FOOD_RNG_OCC_CHECK_EN
        w_cand_x_nxt = r_cand_x;
        w_cand_y_nxt = r_cand_y;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_tries_nxt = '0;
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_in_range) begin
`ifdef FOOD_RNG_OCC_CHECK_EN
                    w_cand_x_nxt = w_cx;
                    w_cand_y_nxt = w_cy;
                    w_state_nxt  = S_CHECK;
`else
                    w_food_x_nxt = w_cx;
                    w_food_y_nxt = w_cy;
                    w_fail_nxt   = 1'b0;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
`endif
                end else if (w_last_try) begin
                    // give up: report the out-of-range candidate flagged as failed
                    w_food_x_nxt = w_cx;
                    w_food_y_nxt = w_cy;
                    w_fail_nxt   = 1'b1;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_tries_nxt = r_tries + TW'(1);
                end
            end
`ifdef FOOD_RNG_OCC_CHECK_EN
            S_CHECK: begin
                if (!occ || w_last_try) begin
                    w_food_x_nxt = r_cand_x;
                    w_food_y_nxt = r_cand_y;
                    w_fail_nxt   = occ;
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_tries_nxt = r_tries + TW'(1);
                    w_state_nxt = S_SAMPLE;
                end
            end
`endif
            S_DONE: begin
                if (ack) begin
                    w_fail_nxt  = 1'b0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= SEED;
            r_state  <= S_IDLE;
            r_tries  <= '0;
            r_food_x <= '0;
            r_food_y <= '0;
            r_fail   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef FOOD_RNG_OCC_CHECK_EN
            r_cand_x <= '0;
            r_cand_y <= '0;
`endif
        end else begin
            // reseeding never disturbs the FSM; a zero seed would lock the LFSR
            if (seed_load) begin
                r_lfsr <= (seed_in == 32'd0) ? SEED : seed_in;
            end else begin
                r_lfsr <= {r_lfsr[30:0], w_lfsr_fb};
            end
            r_state  <= w_state_nxt;
            r_tries  <= w_tries_nxt;
            r_food_x <= w_food_x_nxt;
            r_food_y <= w_food_y_nxt;
            r_fail   <= w_fail_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
`ifdef FOOD_RNG_OCC_CHECK_EN
            r_cand_x <= w_cand_x_nxt;
            r_cand_y <= w_cand_y_nxt;
`endif
        end
    end

    assign valid  = r_valid;
    assign fail   = r_fail;
    assign busy   = r_busy;
    assign food_x = r_food_x;
    assign food_y = r_food_y;

endmodule

// File: doc/food_rng.md
# food_rng

Parametrised food-position generator for the snake game. It replaces the fixed pair of free-running 7-bit LFSRs with a single 32-bit maximal-length LFSR and a request/valid handshake. It delivers one coordinate pair guaranteed inside the playfield (GRID_W × GRID_H) and, optionally, not on a cell occupied by the snake. It sits between the game-control FSM (requester) and the snake-body occupancy lookup.

## Interface
- X_BITS, 7: width of x coordinate.
- Y_BITS, 7: width of y coordinate. X_BITS+Y_BITS ≤ 32.
- GRID_W, 80: legal x range 0..GRID_W-1; 1 ≤ GRID_W ≤ 2^X_BITS.
- GRID_H, 60: legal y range 0..GRID_H-1; 1 ≤ GRID_H ≤ 2^Y_BITS.
- SEED, 32'hACE1_2469: reset/fallback LFSR value; must be nonzero.
- MAX_TRIES, 64: rejections allowed before giving up; ≥ 1.
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high; clock clk.
- seed_load in 1: load seed_in into LFSR this cycle.
- seed_in in 32: new seed; value 0 loads SEED instead.
- req in 1: request a new position (level-sampled in IDLE).
- ack in 1: consumer accepts food_x/food_y while valid=1.
- valid out 1: food_x/food_y/fail are valid; held until ack.
- food_x out X_BITS: result x.
- food_y out Y_BITS: result y.
- fail out 1: MAX_TRIES exhausted; coordinates are the last candidate, not guaranteed legal.
- busy out 1: FSM not in IDLE.
- chk_valid out 1: occupancy query active.
- chk_x out X_BITS, chk_y out Y_BITS: cell being queried.
- occ in 1: combinational reply, 1 = cell occupied; sampled only when chk_valid=1.

## Operation
- LFSR: 32-bit Fibonacci, polynomial x^32+x^22+x^2+x+1, shift left, feedback into bit 0. Advances every cycle except under rst or seed_load. Request timing therefore acts as an entropy source.
- Candidate each SAMPLE cycle: cx = lfsr[X_BITS-1:0], cy = lfsr[X_BITS+Y_BITS-1:X_BITS], taken from the current (pre-shift) register value.
- FSM states: IDLE, SAMPLE, CHECK, DONE.
- IDLE: on req=1, clear tries and go to SAMPLE.
- SAMPLE, cx<GRID_W and cy<GRID_H: latch cand and go to CHECK.
- SAMPLE, candidate out of range: rejection; stay in SAMPLE.
- CHECK: chk_valid=1, chk_x/chk_y=cand.
  - occ=0: latch food_x/food_y=cand, fail=0, go to DONE.
  - occ=1: rejection; go to SAMPLE.
- Rejection handling: tries += 1. If the rejection would make tries==MAX_TRIES, latch food=last candidate, fail=1, go to DONE.
- DONE: valid=1. On ack=1 go to IDLE; valid, fail and busy drop the next cycle. food_x/food_y hold their value until the next result.
- req outside IDLE is ignored. ack without valid is ignored.
- seed_load in any state reseeds only; the FSM continues. rst has priority over seed_load.
- rst mid-operation: all state returns to reset values immediately. No partial result is emitted.
- Reset values: lfsr=SEED, state=IDLE, tries=0, valid=0, fail=0, busy=0, chk_valid=0, chk_x=0, chk_y=0, food_x=0, food_y=0.

## Timing
- All outputs are registered except chk_x/chk_y/chk_valid, which are decoded from state and cand registers (glitch-free, no combinational path from inputs).
- Minimum latency, check enabled: req high at edge k; valid high after edge k+3.
- Minimum latency, check disabled: valid high after edge k+2.
- Each range rejection adds 1 cycle. Each occupancy rejection adds 2 cycles.
- Back-to-back: ack at edge n; a req held high is accepted at edge n+1.
- tries is clog2(MAX_TRIES+1) bits wide. It never wraps.

## Configuration
- FOOD_RNG_OCC_CHECK_EN defined: CHECK state present; occupancy handshake as above.
- FOOD_RNG_OCC_CHECK_EN undefined: no CHECK state. An in-range SAMPLE goes directly to DONE. occ is ignored. chk_valid, chk_x and chk_y are tied 0. Only range rejections count toward MAX_TRIES.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0, lfsr==32'hACE1_2469; seed_load with rst high → no effect.
- Full grid (GRID_W=128, GRID_H=128), occ=0, macro on: pulse req → valid after exactly 3 edges, fail=0, food_x/food_y equal the bench LFSR model's bits at the SAMPLE cycle; ack → valid=0 next cycle.
- Range rejection, GRID_W=GRID_H=5: 200 requests → every food_x<5, food_y<5, fail=0; latency matches model rejection count.
- Occupancy: occ=1 for the first 3 queries, then 0 → food equals the 4th in-range candidate, fail=0, chk_valid seen on 4 cycles.
- Exhaustion: occ tied 1, MAX_TRIES=4 → valid with fail=1 after exactly 4 rejections; seed_in=0 with seed_load → lfsr==SEED; rst asserted in CHECK → IDLE next cycle, valid never rises.
- Macro off: same stimulus as the full-grid scenario → valid after 2 edges, chk_valid constantly 0, occ toggling has no effect.
